// File: rtl/tl_burst_arbiter.sv
// tl_burst_arbiter: round-robin N:1 TileLink arbiter that locks the grant for whole multi-beat bursts
module tl_burst_arbiter #(
    parameter int N        = 4,
    parameter int DATA_W   = 64,
    parameter int SIZE_W   = 3,
    parameter int LOG_BEAT = 3,
    parameter int IDX_W    = $clog2(N),
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        req_valid_i,
    output logic [N-1:0]        req_ready_o,
    input  logic [N*DATA_W-1:0] req_data_i,
    input  logic [N*SIZE_W-1:0] req_size_i,
    input  logic [N-1:0]        req_has_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_W-1:0]   out_data_o,
    output logic [IDX_W-1:0]    out_idx_o,
    output logic                out_last_o,
    output logic                busy_o
);
    typedef enum logic [1:0] {IDLE, HOLD, BURST} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr, lock, rr_g, grant, j;
    logic [CNT_W-1:0]   remain, beats_m1;
    logic [SIZE_W-1:0]  g_size;
    logic               g_hd, multi, fire;

    function automatic logic [IDX_W-1:0] inc(input logic [IDX_W-1:0] i);
        return (int'(i) == N - 1) ? '0 : i + 1'b1;
    endfunction

    // round-robin search from ptr; iterating downwards lets the closest valid requester win
    always_comb begin
        rr_g = ptr;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IDX_W'((int'(ptr) + k) % N);
            if (req_valid_i[j]) rr_g = j;
        end
    end

    // grant, output mux, beat decode and handshake steering
    always_comb begin
        grant = (state == IDLE) ? rr_g : lock;
        out_valid_o = rst_n && ((state == IDLE) ? |req_valid_i : req_valid_i[lock]);
        out_idx_o = out_valid_o ? grant : ptr;
        fire = out_valid_o && out_ready_i;
        g_size = '0;
        g_hd = 1'b0;
        out_data_o = '0;
        req_ready_o = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == IDX_W'(i)) begin
                g_size = req_size_i[i*SIZE_W +: SIZE_W];
                g_hd = req_has_data_i[i];
                req_ready_o[i] = fire;
            end
            if (out_idx_o == IDX_W'(i)) out_data_o = req_data_i[i*DATA_W +: DATA_W];
        end
        multi = g_hd && (g_size > SIZE_W'(LOG_BEAT));
        beats_m1 = (CNT_W'(1) << (g_size - SIZE_W'(LOG_BEAT))) - CNT_W'(1);
        out_last_o = rst_n && ((state == BURST) ? (remain == CNT_W'(1)) : !multi);
        busy_o = rst_n && (state != IDLE);
    end

    // arbitration FSM: hold a stalled offer, lock the grant through a burst, advance ptr after the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            lock <= '0;
            remain <= '0;
        end else if (state == BURST) begin
            if (fire) begin
                remain <= remain - 1'b1;
                if (remain == CNT_W'(1)) begin
                    state <= IDLE;
                    ptr <= inc(lock);
                end
            end
        end else if (fire) begin
            if (multi) begin
                state <= BURST;
                lock <= grant;
                remain <= beats_m1;
            end else begin
                state <= IDLE;
                ptr <= inc(grant);
            end
        end else if (state == IDLE && out_valid_o) begin
            state <= HOLD;
            lock <= grant;
        end else if (state == HOLD && !out_valid_o) begin
            state <= IDLE;
        end
    end
endmodule
